mix_char_conv: RTL and testbench



---
 rtl/mix_pkg.sv | 48 ++++
 rtl/bcd_add3_step.sv | 18 +
 rtl/mix_char_conv.sv | 120 ++++++++++++
 tb/tb_mix_char_conv.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// -----------------------------------------------------------------------------
// mix_pkg
// Shared constants and types for the MIX execute units.
//
// Configuration macro: MIX_CHAR_2BIT_EN
//   defined   -> the CHAR converter consumes two input bits per iteration
//                (15 iterations).
//   undefined -> one input bit per iteration (30 iterations).
// -----------------------------------------------------------------------------
package mix_pkg;

   localparam int MIX_WORD_W      = 30;
   localparam int MIX_BYTE_W      = 6;
   localparam int MIX_CHAR_DIGITS = 10;
   localparam int MIX_CHAR_BCD_W  = 4 * MIX_CHAR_DIGITS;
   localparam int MIX_CHAR_OUT_W  = MIX_BYTE_W * MIX_CHAR_DIGITS;

   localparam logic [MIX_BYTE_W-1:0] MIX_CHAR_ZERO = 6'd30;

`ifdef MIX_CHAR_2BIT_EN
   localparam int MIX_CHAR_BITS_PER_ITER = 2;
`else
   localparam int MIX_CHAR_BITS_PER_ITER = 1;
`endif

   // Value of the iteration counter during the final iteration.
   localparam logic [4:0] MIX_CHAR_LAST_ITER =
      5'(MIX_WORD_W / MIX_CHAR_BITS_PER_ITER - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } char_state_t;

   // Map ten packed BCD digits onto ten MIX character codes ('0' = 30).
   function automatic logic [MIX_CHAR_OUT_W-1:0] bcd_to_chars(
      input logic [MIX_CHAR_BCD_W-1:0] bcd
   );
      logic [MIX_CHAR_OUT_W-1:0] chars;
      chars = '0;
      for (int i = 0; i < MIX_CHAR_DIGITS; i++) begin
         chars[MIX_BYTE_W*i +: MIX_BYTE_W] = MIX_CHAR_ZERO + {2'b00, bcd[4*i +: 4]};
      end
      return chars;
   endfunction

endpackage : mix_pkg

// File: rtl/bcd_add3_step.sv
// -----------------------------------------------------------------------------
// bcd_add3_step
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next
// decimal digit.
//
// Ports:
//   digit_i  in  4  BCD digit before correction
//   digit_o  out 4  corrected digit
// -----------------------------------------------------------------------------
module bcd_add3_step (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule : bcd_add3_step

// File: rtl/mix_char_conv.sv
// -----------------------------------------------------------------------------
// mix_char_conv
// Multi-cycle binary-to-character converter for the MIX CHAR operation.
// Converts a 30-bit magnitude into ten MIX digit characters (30..39) with
// leading zeros, using iterative shift-and-add-3 (double dabble), MSB first.
//
// Configuration macro: MIX_CHAR_2BIT_EN (two bits per iteration, 15 cycles;
// otherwise one bit per iteration, 30 cycles).
//
// Ports:
//   clk    in  1   system clock, rising edge
//   reset  in  1   asynchronous, active-low reset
//   start  in  1   one-cycle conversion request (accepted only when idle)
//   in     in  30  unsigned magnitude, sampled when start is accepted
//   out    out 60  ten character codes, out[59:54] = most significant digit
//   stop   out 1   one-cycle pulse, out valid from this cycle on
// -----------------------------------------------------------------------------
module mix_char_conv
   import mix_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [MIX_WORD_W-1:0]     in,
   output logic [MIX_CHAR_OUT_W-1:0] out,
   output logic                      stop
);

   char_state_t               state_q;
   logic [MIX_WORD_W-1:0]     sh_q, sh_d;
   logic [MIX_CHAR_BCD_W-1:0] bcd_q, bcd_d;
   logic [4:0]                cnt_q;
   logic [MIX_CHAR_OUT_W-1:0] out_q;
   logic                      stop_q;

   // First add-3/shift stage.
   logic [MIX_CHAR_BCD_W-1:0] adj_a, bcd_a;
   logic [MIX_WORD_W-1:0]     sh_a;

   for (genvar d = 0; d < MIX_CHAR_DIGITS; d++) begin : g_stage_a
      bcd_add3_step u_add3 (
         .digit_i (bcd_q[4*d +: 4]),
         .digit_o (adj_a[4*d +: 4])
      );
   end

   assign bcd_a = {adj_a[MIX_CHAR_BCD_W-2:0], sh_q[MIX_WORD_W-1]};
   assign sh_a  = {sh_q[MIX_WORD_W-2:0], 1'b0};

`ifdef MIX_CHAR_2BIT_EN
   // Second stage chained behind the first: two input bits per cycle.
   logic [MIX_CHAR_BCD_W-1:0] adj_b;

   for (genvar d = 0; d < MIX_CHAR_DIGITS; d++) begin : g_stage_b
      bcd_add3_step u_add3 (
         .digit_i (bcd_a[4*d +: 4]),
         .digit_o (adj_b[4*d +: 4])
      );
   end

   assign bcd_d = {adj_b[MIX_CHAR_BCD_W-2:0], sh_a[MIX_WORD_W-1]};
   assign sh_d  = {sh_a[MIX_WORD_W-2:0], 1'b0};

   // A 30-bit value never reaches 8 in the top digit, so the shifted-out
   // MSB of each stage is always zero.
   logic unused_top;
   assign unused_top = adj_a[MIX_CHAR_BCD_W-1] ^ adj_b[MIX_CHAR_BCD_W-1];
`else
   assign bcd_d = bcd_a;
   assign sh_d  = sh_a;

   logic unused_top;
   assign unused_top = adj_a[MIX_CHAR_BCD_W-1];
`endif

   // DONE is the single cycle in which stop is high. It behaves exactly like
   // IDLE, so a start arriving alongside stop is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values; blocking here would chain iterations in one cycle.
         case (state_q)
            IDLE, DONE: begin
               stop_q <= 1'b0;
               if (start) begin
                  sh_q    <= in;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               sh_q  <= sh_d;
               bcd_q <= bcd_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == MIX_CHAR_LAST_ITER) begin
                  // Register the result from the final iteration directly.
                  out_q   <= bcd_to_chars(bcd_d);
                  stop_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out  = out_q;
   assign stop = stop_q;

endmodule : mix_char_conv

// File: tb/tb_mix_char_conv.sv
// -----------------------------------------------------------------------------
// tb_mix_char_conv
// Self-checking bench for mix_char_conv. Expected characters come from a
// decimal model (repeated %10 and /10); latency is 30 cycles, or 15 cycles
// when MIX_CHAR_2BIT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mix_char_conv;

`ifdef MIX_CHAR_2BIT_EN
   localparam int EXP_LAT = 15;
`else
   localparam int EXP_LAT = 30;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [29:0] in_v;
   logic [59:0] out_w;
   logic        stop;

   int n_cmp = 0;
   int n_bad = 0;

   mix_char_conv dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .in    (in_v),
      .out   (out_w),
      .stop  (stop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Decimal reference: ten digits, least significant in the lowest byte.
   function automatic logic [59:0] ref_chars(input logic [29:0] v);
      logic [59:0] r;
      int unsigned x;
      x = v;
      r = '0;
      for (int i = 0; i < 10; i++) begin
         r[6*i +: 6] = 6'(30 + x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [59:0] pack_bytes(input int b[10]);
      logic [59:0] r;
      r = '0;
      for (int i = 0; i < 10; i++) r[6*(9-i) +: 6] = 6'(b[i]);
      return r;
   endfunction

   // Runs one conversion. With b2b set, the caller is just after the edge
   // that raised stop, and start is driven into that stop cycle.
   task automatic convert(input logic [29:0] v, input bit b2b,
                          output int lat, output logic [59:0] res);
      logic [59:0] prev;
      bit          hold_ok;
      if (!b2b) @(negedge clk);
      start = 1'b1;
      in_v  = v;
      prev  = out_w;
      @(posedge clk);                // E0
      #1;
      start   = 1'b0;
      in_v    = 30'($urandom);       // must not affect the result
      lat     = -1;
      res     = '0;
      hold_ok = 1'b1;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk);
         #1;
         if (stop) begin
            lat = k;
            res = out_w;
         end else if (out_w !== prev) begin
            hold_ok = 1'b0;
         end
      end
      check("out_hold", 64'(hold_ok), 64'd1);
   endtask

   int          lat, first_k, n_stop;
   logic [59:0] res;
   logic [29:0] v, v2;
   int          b_12977[10] = '{30, 30, 30, 30, 30, 31, 32, 39, 37, 37};
   int          b_max[10]   = '{31, 30, 37, 33, 37, 34, 31, 38, 32, 33};

   initial begin
      reset = 1'b0;
      start = 1'b0;
      in_v  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", 64'(out_w), 64'd0);
      check("reset_stop", 64'(stop), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Zero input, latency and one-cycle stop.
      convert(30'd0, 1'b0, lat, res);
      check("zero_out", 64'(res), 64'(ref_chars(30'd0)));
      check("zero_lat", 64'(lat), 64'(EXP_LAT));
      @(posedge clk);
      #1;
      check("zero_stop_width", 64'(stop), 64'd0);
      check("zero_out_held", 64'(out_w), 64'(ref_chars(30'd0)));

      convert(30'd12977, 1'b0, lat, res);
      check("v12977_out", 64'(res), 64'(pack_bytes(b_12977)));
      check("v12977_lat", 64'(lat), 64'(EXP_LAT));

      convert(30'd1073741823, 1'b0, lat, res);
      check("max_out", 64'(res), 64'(pack_bytes(b_max)));
      check("max_lat", 64'(lat), 64'(EXP_LAT));

      // Back-to-back: start in the cycle stop is high.
      convert(30'd987654321, 1'b1, lat, res);
      check("b2b_out", 64'(res), 64'(ref_chars(30'd987654321)));
      check("b2b_lat", 64'(lat), 64'(EXP_LAT));

      // Second start 10 cycles into a conversion is ignored.
      @(negedge clk);
      start = 1'b1;
      in_v  = 30'd12977;
      @(posedge clk);
      #1;
      start   = 1'b0;
      first_k = -1;
      n_stop  = 0;
      res     = '0;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) begin
            start = 1'b1;
            in_v  = 30'd999;
         end else if (k == 11) begin
            start = 1'b0;
         end
         if (stop) begin
            n_stop++;
            if (first_k < 0) begin
               first_k = k;
               res     = out_w;
            end
         end
      end
      check("ign_stop_count", 64'(n_stop), 64'd1);
      check("ign_lat", 64'(first_k), 64'(EXP_LAT));
      check("ign_out", 64'(res), 64'(pack_bytes(b_12977)));
      check("ign_out_final", 64'(out_w), 64'(pack_bytes(b_12977)));

      // Reset during iteration 12 aborts the conversion.
      @(negedge clk);
      start = 1'b1;
      in_v  = 30'd12977;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("abort_out", 64'(out_w), 64'd0);
      check("abort_stop", 64'(stop), 64'd0);
      @(posedge clk);
      #1;
      reset  = 1'b1;
      n_stop = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (stop) n_stop++;
      end
      check("abort_no_stop", 64'(n_stop), 64'd0);
      check("abort_out_after", 64'(out_w), 64'd0);
      convert(30'd5, 1'b0, lat, res);
      check("after_abort_out", 64'(res), 64'({{9{6'd30}}, 6'd35}));
      check("after_abort_lat", 64'(lat), 64'(EXP_LAT));

      // Random regression.
      for (int i = 0; i < 1000; i++) begin
         bit b2b;
         case ($urandom_range(0, 3))
            0:       v = 30'($urandom_range(0, 999));
            1:       v = 30'd1073741823 - 30'($urandom_range(0, 999));
            default: v = 30'($urandom);
         endcase
         b2b = ($urandom_range(0, 3) == 0);
         if (!b2b) begin
            @(posedge clk);
            #1;
            check("rnd_stop_width", 64'(stop), 64'd0);
         end
         convert(v, b2b, lat, res);
         check("rnd_out", 64'(res), 64'(ref_chars(v)));
         check("rnd_lat", 64'(lat), 64'(EXP_LAT));
      end

      // Output holds when idle.
      v2 = v;
      repeat (5) @(posedge clk);
      #1;
      check("idle_hold", 64'(out_w), 64'(ref_chars(v2)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mix_char_conv
